rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter sequencing a shared 4:1 bit-select mux among four
//   requesters. Grants one requester at a time, drives the mux select and
//   returns the granted requester's data bit, registered. Bounds tenure with a
//   hold timeout. Sits in front of the 4:1 mux datapath as its select controller.
// PARAMETERS
//   MAX_HOLD  8  max consecutive grant cycles per tenure (legal range 1..15)
//   HOLD_W    4  width of hold counter; must hold MAX_HOLD-1
// PORTS
//   clk     in   1  single clock; all state updates on rising edge
//   reset   in   1  synchronous, active-high reset
//   req     in   4  request per requester; granted requester holds high to keep grant
//   d       in   4  data bit per requester, muxed by select
//   grant   out  4  one-hot grant, registered; 4'b0000 when idle
//   select  out  2  index of granted requester, registered; drives mux select
//   busy    out  1  high while a grant is active (== |grant)
//   q       out  1  registered d[select]; 0 when not busy
// BEHAVIOUR
//   Reset (reset=1 at edge, overrides all else): state=IDLE, grant=0, select=0,
//     busy=0, q=0, ptr=0, hold_cnt=0. Reset mid-tenure drops grant the next edge.
//   Arbitration: scan req from index ptr upward, mod 4; first set bit wins.
//   IDLE: req==0 -> stay. Any req set -> next edge: grant=onehot(win),
//     select=win, busy=1, hold_cnt=0, state=GRANT. Req-to-grant latency 1 cycle.
//   GRANT, each edge: release if req[select]==0 OR hold_cnt==MAX_HOLD-1, else hold_cnt+1.
//   On release:
//     - ptr <= select+1 (mod 4, 2-bit wrap 3->0).
//     - Re-arbitrate same edge using new ptr over current req.
//     - Winner exists: back-to-back handover, no idle gap; grant/select = winner, hold_cnt=0.
//     - Timed-out requester still requesting and no one else requesting:
//       re-granted via wrap, new tenure.
//     - No winner: state=IDLE, grant=0, busy=0.
//   Drop and timeout same cycle: single release; behaves as above.
//   Non-granted req changes during GRANT have no effect until a release.
//   q: each edge q <= busy ? d[select] : 0, using pre-edge busy/select.
//     q lags grant by one cycle; first valid q is the edge after grant rises.
//   grant always zero or one-hot; select never changes without a release.
//   MAX_HOLD=1: every tenure is one cycle; continuous requesters rotate each cycle.
// TESTING
//   1. Reset, req=4'b0100 held -> 1 cycle later grant=4'b0100, select=2, busy=1;
//      d=4'b0100 -> q=1 next cycle.
//   2. req=4'b1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0, each 8 cycles,
//      no idle gap between tenures.
//   3. Grant to 1, drop req[1] after 3 cycles while req[3]=1 -> next edge
//      grant=4'b1000, ptr=2.
//   4. Only req[3] held -> grant 3 for 8 cycles, timeout, re-granted 3 (wrap),
//      hold_cnt restarts; busy stays 1.
//   5. reset=1 mid-tenure with req=4'b1111 -> next edge grant=0, q=0, busy=0;
//      after release grant goes to requester 0.
//   6. Single req pulse 1 cycle on req[0] -> grant=4'b0001 one cycle, then IDLE,
//      grant=0, q returns 0 one cycle later.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin select controller for a shared 4:1 bit mux: grants one of four
// requesters, bounds each tenure with a hold timeout and registers the muxed bit.
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       q
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        select_q, select_d;
  logic              q_q, q_d;
  logic [2:0]        arb_idle, arb_rel;
  logic              release_now;

  // Returns {found, index}; lowest offset from ptr wins, so scan offsets downward.
  function automatic logic [2:0] arbitrate(input logic [1:0] ptr, input logic [3:0] req_v);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req_v[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      grant_q    <= 4'b0000;
      select_q   <= 2'd0;
      q_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      select_q   <= select_d;
      q_q        <= q_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant_q;
    select_d    = select_q;
    arb_idle    = arbitrate(ptr_q, req);
    release_now = 1'b0;
    arb_rel     = 3'b000;
    case (state_q)
      IDLE: begin
        if (arb_idle[2]) begin
          state_d    = GRANT;
          grant_d    = 4'b0001 << arb_idle[1:0];
          select_d   = arb_idle[1:0];
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        release_now = !req[select_q] || (hold_cnt_q == HOLD_LAST);
        if (release_now) begin
          // Re-arbitrate on the same edge from the advanced pointer for gapless handover.
          ptr_d      = select_q + 2'd1;
          arb_rel    = arbitrate(ptr_d, req);
          hold_cnt_d = '0;
          if (arb_rel[2]) begin
            grant_d  = 4'b0001 << arb_rel[1:0];
            select_d = arb_rel[1:0];
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_comb begin
    busy   = |grant_q;
    grant  = grant_q;
    select = select_q;
    q      = q_q;
    q_d    = busy ? d[select_q] : 1'b0;
  end

endmodule
